// File: rtl/rom_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_access_arbiter_if
// Brief    : Request/grant/data bundle between ROM requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface rom_access_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] rom_data;
    logic              rom_select;
    logic              grant0;
    logic              grant1;
    logic              valid0;
    logic              valid1;
    logic [DATA_W-1:0] data;
    logic              busy;

    modport master (
        output req0, req1, rom_data,
        input  rom_select, grant0, grant1, valid0, valid1, data, busy
    );

    modport slave (
        input  req0, req1, rom_data,
        output rom_select, grant0, grant1, valid0, valid1, data, busy
    );
endinterface
`default_nettype wire

// File: rtl/rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_access_arbiter
// Brief    : Round-robin sharing of the program ROM between CPU fetch and the
//            loader port; counts ROM latency and returns the captured word.
// Revision : 1.0
// ============================================================================
module rom_access_arbiter #(
    parameter int ROM_LATENCY = 1,
    parameter int DATA_W      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rom_access_arbiter_if.slave   bus
);
    localparam int c_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_last;
    logic                 r_sel;
    logic                 r_grant0;
    logic                 r_grant1;
    logic                 r_valid0;
    logic                 r_valid1;
    logic [DATA_W-1:0]    r_data;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_last_nxt;
    logic                 w_sel_nxt;
    logic                 w_grant0_nxt;
    logic                 w_grant1_nxt;
    logic                 w_valid0_nxt;
    logic                 w_valid1_nxt;
    logic [DATA_W-1:0]    w_data_nxt;
    logic                 w_busy_nxt;
    logic                 w_winner;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_sel_nxt    = r_sel;
        w_grant0_nxt = 1'b0;
        w_grant1_nxt = 1'b0;
        w_valid0_nxt = 1'b0;
        w_valid1_nxt = 1'b0;
        w_data_nxt   = r_data;
        w_busy_nxt   = r_busy;
        // On a tie the requester that did not win last time goes next.
        w_winner     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;

        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_sel_nxt    = w_winner;
                    w_grant0_nxt = ~w_winner;
                    w_grant1_nxt = w_winner;
                    w_last_nxt   = w_winner;
                    w_cnt_nxt    = c_CNT_W'(ROM_LATENCY - 1);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_data_nxt   = bus.rom_data;
                    w_valid0_nxt = ~r_sel;
                    w_valid1_nxt = r_sel;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_data   <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_sel    <= w_sel_nxt;
            r_grant0 <= w_grant0_nxt;
            r_grant1 <= w_grant1_nxt;
            r_valid0 <= w_valid0_nxt;
            r_valid1 <= w_valid1_nxt;
            r_data   <= w_data_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign bus.rom_select = r_sel;
    assign bus.grant0     = r_grant0;
    assign bus.grant1     = r_grant1;
    assign bus.valid0     = r_valid0;
    assign bus.valid1     = r_valid1;
    assign bus.data       = r_data;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_rom_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_access_arbiter
// Brief    : Directed scoreboard bench; one arbiter with latency 1, one with 3.
// Revision : 1.0
// ============================================================================
module tb_rom_access_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    typedef struct {
        int          dut;
        int          code;   // 0=grant0 1=grant1 2=valid0 3=valid1
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    rom_access_arbiter_if #(.DATA_W(16)) if1 ();
    rom_access_arbiter_if #(.DATA_W(16)) if3 ();

    rom_access_arbiter #(.ROM_LATENCY(1), .DATA_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    rom_access_arbiter #(.ROM_LATENCY(3), .DATA_W(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input int d, input int code, input int c, input logic [15:0] dat);
        exp_t e;
        e.dut  = d;
        e.code = code;
        e.cyc  = c;
        e.data = dat;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int d, input logic [3:0] ev, input logic [15:0] dat, input logic sel);
        exp_t e;
        if (ev != 4'b0000)
            check("one_event_per_cycle", $countones(ev), 1);
        for (int b = 0; b < 4; b++) begin
            if (ev[b]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event at cycle %0d: dut %0d event %0d, expected none", cyc, d, b);
                end else begin
                    e = exp_q.pop_front();
                    check("event_id", d * 4 + b, e.dut * 4 + e.code);
                    check("event_cycle", cyc, e.cyc);
                    check("event_select", {31'd0, sel}, e.code % 2);
                    if (b >= 2)
                        check("valid_data", {16'd0, dat}, {16'd0, e.data});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1, {if1.valid1, if1.valid0, if1.grant1, if1.grant0}, if1.data, if1.rom_select);
        mon(3, {if3.valid1, if3.valid0, if3.grant1, if3.grant0}, if3.data, if3.rom_select);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero3(input string name);
        check({name, "_grants"},  {30'd0, if3.grant1, if3.grant0}, 0);
        check({name, "_valids"},  {30'd0, if3.valid1, if3.valid0}, 0);
        check({name, "_busy_sel"}, {30'd0, if3.busy, if3.rom_select}, 0);
        check({name, "_data"},    {16'd0, if3.data}, 0);
    endtask

    int k;

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        rst = 1'b1;
        if1.req0 = 0; if1.req1 = 0; if1.rom_data = 16'h0;
        if3.req0 = 0; if3.req1 = 0; if3.rom_data = 16'h0;
        tick(2);
        check("reset_dut1", {if1.busy, if1.rom_select, if1.grant0, if1.grant1,
                             if1.valid0, if1.valid1, if1.data}, 0);
        check_zero3("reset_dut3");
        rst = 1'b0;
        tick(1);

        // Single requester, latency 1
        k = cyc;
        if1.rom_data = 16'hA5A5;
        if1.req0 = 1;
        push(1, 0, k + 1, 16'h0);
        push(1, 2, k + 2, 16'hA5A5);
        @(negedge clk);
        if1.req0 = 0;
        check("t1_busy_grant", {30'd0, if1.busy, if1.rom_select}, 2);
        @(negedge clk);
        check("t1_busy_valid", {30'd0, if1.busy, if1.rom_select}, 0);
        check("t1_data", {16'd0, if1.data}, 32'hA5A5);
        tick(2);

        // Both held after reset: 0,1,0,1 every 2 cycles
        do_reset();
        k = cyc;
        if1.rom_data = 16'h1111;
        if1.req0 = 1; if1.req1 = 1;
        for (int i = 0; i < 4; i++) begin
            push(1, i % 2, k + 1 + 2 * i, 16'h0);
            push(1, 2 + (i % 2), k + 2 + 2 * i, 16'h1111);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0)
                check("t2_select", {31'd0, if1.rom_select}, (i / 2) % 2);
            if (i == 6) begin
                if1.req0 = 0; if1.req1 = 0;
            end
        end
        tick(2);

        // Latency 3, requester 1
        k = cyc;
        if3.rom_data = 16'h1234;
        if3.req1 = 1;
        push(3, 1, k + 1, 16'h0);
        push(3, 3, k + 4, 16'h1234);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) if3.req1 = 0;
            check("t3_select", {31'd0, if3.rom_select}, 1);
            check("t3_busy", {31'd0, if3.busy}, (i <= 3) ? 1 : 0);
        end
        tick(2);

        // Requests change during WAIT
        k = cyc;
        if3.rom_data = 16'h0F0F;
        if3.req0 = 1;
        push(3, 0, k + 1, 16'h0);
        push(3, 2, k + 4, 16'h0F0F);
        push(3, 1, k + 5, 16'h0);
        push(3, 3, k + 8, 16'h0F0F);
        @(negedge clk);
        if3.req0 = 0;
        @(negedge clk);
        if3.req1 = 1;
        tick(3);
        if3.req1 = 0;
        check("t4_select", {31'd0, if3.rom_select}, 1);
        tick(5);

        // Reset mid-access; requester 0 wins after release
        k = cyc;
        if3.rom_data = 16'h5A5A;
        if3.req0 = 1;
        push(3, 0, k + 1, 16'h0);
        @(negedge clk);
        if3.req0 = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero3("t5_async");
        @(negedge clk);
        check_zero3("t5_held");
        rst = 1'b0;
        if3.req0 = 1; if3.req1 = 1;
        push(3, 0, k + 4, 16'h0);
        push(3, 2, k + 7, 16'h5A5A);
        @(negedge clk);
        if3.req0 = 0; if3.req1 = 0;
        tick(5);

        // Data holds while idle
        k = cyc;
        if3.rom_data = 16'hBEEF;
        if3.req1 = 1;
        push(3, 1, k + 1, 16'h0);
        push(3, 3, k + 4, 16'hBEEF);
        @(negedge clk);
        if3.req1 = 0;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            if3.rom_data = 16'($urandom);
            @(negedge clk);
            check("t6_data_hold", {16'd0, if3.data}, 32'hBEEF);
            check("t6_idle", {31'd0, if3.busy}, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
